// File: rtl/acc_core_seq_if.sv
// rtl/acc_core_seq_if.sv - program/data RAM bus between the sequencer (master) and the RAM (slave)
interface acc_core_seq_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr_ins;
    logic [ADDR_W-1:0] addr_data;
    logic              ram_we;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] mdr_ins;
    logic [DATA_W-1:0] mdr_data;

    modport master (
        output addr_ins, addr_data, ram_we, data_out,
        input  mdr_ins, mdr_data
    );

    modport slave (
        input  addr_ins, addr_data, ram_we, data_out,
        output mdr_ins, mdr_data
    );
endinterface

// File: rtl/acc_core_seq.sv
// rtl/acc_core_seq.sv - two-cycle-per-instruction accumulator sequencer; ILLEGAL_TRAP_EN halts on opcodes 1010-1111
module acc_core_seq #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    acc_core_seq_if.master    bus,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
`ifdef ILLEGAL_TRAP_EN
    output logic              illegal,
`endif
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_CLA = 4'h0;
    localparam logic [3:0] OP_COM = 4'h1;
    localparam logic [3:0] OP_SHR = 4'h2;
    localparam logic [3:0] OP_CSL = 4'h3;
    localparam logic [3:0] OP_STP = 4'h4;
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_STA = 4'h6;
    localparam logic [3:0] OP_LDA = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_BAN = 4'h9;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ipc;
    logic [3:0]        op;
    logic [ADDR_W-1:0] operand;
    logic              op_illegal;

    assign op         = ir[DATA_W-1:ADDR_W];
    assign operand    = ir[ADDR_W-1:0];
    assign op_illegal = (op > OP_BAN);

    assign bus.addr_ins  = pc;
    assign bus.addr_data = operand;
    assign bus.data_out  = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ram_we is decoded from the registered state so a reset kills it without waiting for a clock.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        halted     = 1'b0;
        bus.ram_we = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                halted = (state == S_HALT);
                if (start) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                busy      = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                busy       = 1'b1;
                bus.ram_we = (op == OP_STA);
                state_nxt  = S_FETCH;
                if (op == OP_STP) begin
                    state_nxt = S_HALT;
                end
`ifdef ILLEGAL_TRAP_EN
                if (op_illegal) begin
                    state_nxt = S_HALT;
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            ipc         <= '0;
            acc         <= '0;
            ir          <= '0;
            instr_count <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc          <= '0;
                        ir          <= '0;
                        instr_count <= '0;
`ifdef ILLEGAL_TRAP_EN
                        illegal     <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    ir  <= bus.mdr_ins;
                    ipc <= pc;
                    pc  <= pc + ADDR_W'(1);
                end
                S_EXEC: begin
                    if (instr_count != '1) begin
                        instr_count <= instr_count + CNT_W'(1);
                    end
                    case (op)
                        OP_CLA: acc <= '0;
                        OP_COM: acc <= ~acc;
                        OP_SHR: acc <= {acc[DATA_W-1], acc[DATA_W-1:1]};
                        OP_CSL: acc <= {acc[DATA_W-2:0], acc[DATA_W-1]};
                        OP_ADD: acc <= acc + bus.mdr_data;
                        OP_LDA: acc <= bus.mdr_data;
                        OP_JMP: pc  <= operand;
                        // Branch offset is relative to the BAN itself, not to the already-incremented pc.
                        OP_BAN: if (acc[DATA_W-1]) pc <= ipc + operand;
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            if (op_illegal) begin
                                illegal <= 1'b1;
                            end
`endif
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

`ifndef ILLEGAL_TRAP_EN
    logic unused_illegal;
    assign unused_illegal = op_illegal;
`endif

endmodule

// File: tb/tb_acc_core_seq.sv
// tb/tb_acc_core_seq.sv - randomized and directed bench for acc_core_seq against an ISA-level model
module tb_acc_core_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  acc;
    logic [3:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    acc_core_seq_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    acc_core_seq #(.ADDR_W(4), .DATA_W(8), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus),
        .acc         (acc),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
`ifdef ILLEGAL_TRAP_EN
        .illegal     (illegal),
`endif
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    logic [7:0] mem  [16];
    logic [7:0] prog [16];
    logic       load_en = 1'b0;

    assign bus.mdr_ins  = mem[bus.addr_ins];
    assign bus.mdr_data = mem[bus.addr_data];

    always @(negedge clk) begin
        if (load_en) begin
            for (int a = 0; a < 16; a++) mem[a] <= prog[a];
        end else if (bus.ram_we) begin
            mem[bus.addr_data] <= bus.data_out;
        end
    end

    // ISA-level reference state
    logic [7:0]  mm [16];
    logic [7:0]  m_acc = 8'h00;
    logic [3:0]  m_pc;
    logic [15:0] m_cnt;
    logic        m_ill;
    logic [7:0]  acc_hist [$];
    logic [3:0]  pc_hist  [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic load_prog();
        for (int a = 0; a < 16; a++) mm[a] = prog[a];
        load_en = 1'b1;
        @(negedge clk);
        #1 load_en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        m_acc = 8'h00;
    endtask

    task automatic clear_prog();
        for (int a = 0; a < 16; a++) prog[a] = 8'h00;
    endtask

    task automatic run_prog(input int max_instr);
        logic [3:0] op, x, ipc;
        logic       halt;
        acc_hist.delete();
        pc_hist.delete();
        m_pc = 4'h0; m_cnt = 16'h0; m_ill = 1'b0; halt = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int i = 0; i < max_instr && !halt; i++) begin
            op  = mm[m_pc][7:4];
            x   = mm[m_pc][3:0];
            ipc = m_pc;
            m_pc = m_pc + 4'h1;
            @(posedge clk);
            #2;
            check("ram_we_exec", bus.ram_we, op == 4'h6);
            check("addr_ins_exec", bus.addr_ins, m_pc);
            if (op == 4'h6) begin
                check("sta_addr_data", bus.addr_data, x);
                check("sta_data_out", bus.data_out, m_acc);
            end
            case (op)
                4'h0: m_acc = 8'h00;
                4'h1: m_acc = ~m_acc;
                4'h2: m_acc = $signed(m_acc) >>> 1;
                4'h3: m_acc = (m_acc << 1) | (m_acc >> 7);
                4'h4: halt = 1'b1;
                4'h5: m_acc = m_acc + mm[x];
                4'h6: mm[x] = m_acc;
                4'h7: m_acc = mm[x];
                4'h8: m_pc = x;
                4'h9: if (m_acc >= 8'h80) m_pc = ipc + x;
                default: begin
`ifdef ILLEGAL_TRAP_EN
                    halt  = 1'b1;
                    m_ill = 1'b1;
`endif
                end
            endcase
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
            @(posedge clk);
            #2;
            check("acc", acc, m_acc);
            check("pc", pc, m_pc);
            check("instr_count", instr_count, m_cnt);
            check("halted", halted, halt);
            check("busy", busy, !halt);
            check("ram_we_after", bus.ram_we, 0);
`ifdef ILLEGAL_TRAP_EN
            check("illegal", illegal, m_ill);
`endif
            acc_hist.push_back(acc);
            pc_hist.push_back(pc);
        end
        for (int a = 0; a < 16; a++) check($sformatf("mem%0d", a), mem[a], mm[a]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        logic [7:0] alu_exp [5];
        alu_exp[0] = 8'h81; alu_exp[1] = 8'hC0; alu_exp[2] = 8'h81;
        alu_exp[3] = 8'h7E; alu_exp[4] = 8'h00;

        // Reset state, then idle with no fetch until start
        clear_prog();
        load_prog();
        #1;
        check("rst_acc", acc, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_cnt", instr_count, 0);
        check("rst_we", bus.ram_we, 0);
        do_reset();
        repeat (4) @(posedge clk);
        #2;
        check("idle_busy", busy, 0);
        check("idle_pc", pc, 0);

        // Reset during the EXEC of an STA: write enable must drop, no write lands
        clear_prog();
        prog[0] = 8'h7F; prog[1] = 8'h6D; prog[2] = 8'h40;
        prog[13] = 8'h33; prog[15] = 8'h5A;
        load_prog();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk); #2;
        check("midrun_we_before", bus.ram_we, 1);
        rst_n = 1'b0;
        #1;
        check("midrun_we", bus.ram_we, 0);
        check("midrun_acc", acc, 0);
        check("midrun_pc", pc, 0);
        check("midrun_busy", busy, 0);
        check("midrun_cnt", instr_count, 0);
        @(negedge clk); #1;
        check("midrun_nowrite", mem[13], 8'h33);
        @(posedge clk); #2 rst_n = 1'b1;
        m_acc = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        check("midrun_idle", busy, 0);

        // Gauss sum program
        clear_prog();
        prog[0] = 8'h79; prog[1] = 8'h5A; prog[2] = 8'h6A; prog[3] = 8'h79;
        prog[4] = 8'h5B; prog[5] = 8'h93; prog[6] = 8'h69; prog[7] = 8'h81;
        prog[8] = 8'h40; prog[9] = 8'h09; prog[10] = 8'h00; prog[11] = 8'hFF;
        load_prog();
        run_prog(200);
        check("gauss_m10", mem[10], 8'h2D);
        check("gauss_m9", mem[9], 8'h00);
        check("gauss_acc", acc, 8'hFF);
        check("gauss_cnt", instr_count, 70);
        check("gauss_pc", pc, 9);
        check("gauss_halted", halted, 1);

        // ALU ops, restarted from HALT without reset
        clear_prog();
        prog[0] = 8'h7F; prog[1] = 8'h20; prog[2] = 8'h30; prog[3] = 8'h10;
        prog[4] = 8'h00; prog[5] = 8'h40; prog[15] = 8'h81;
        load_prog();
        run_prog(20);
        for (int i = 0; i < 5; i++) check($sformatf("alu_acc%0d", i), acc_hist[i], alu_exp[i]);

        // BAN not taken, then taken with wraparound
        do_reset();
        clear_prog();
        prog[0] = 8'h7D; prog[1] = 8'h93; prog[2] = 8'h7C; prog[3] = 8'h8E;
        prog[4] = 8'h40; prog[12] = 8'h80; prog[13] = 8'h7F; prog[14] = 8'h93;
        load_prog();
        run_prog(20);
        check("ban_not_taken", pc_hist[1], 2);
        check("ban_wrap", pc_hist[4], 1);
        check("ban_taken", pc_hist[5], 4);

        // STA then reload
        do_reset();
        clear_prog();
        prog[0] = 8'h7F; prog[1] = 8'h6D; prog[2] = 8'h00; prog[3] = 8'h7D;
        prog[4] = 8'h40; prog[15] = 8'h5A;
        load_prog();
        run_prog(20);
        check("sta_mem", mem[13], 8'h5A);
        check("sta_reload_acc", acc, 8'h5A);

        // Opcode 0xA at address 2
        do_reset();
        clear_prog();
        prog[2] = 8'hA0; prog[3] = 8'h40;
        load_prog();
        run_prog(20);
        check("illop_halted", halted, 1);
`ifdef ILLEGAL_TRAP_EN
        check("illop_flag", illegal, 1);
        check("illop_cnt", instr_count, 3);
`else
        check("illop_cnt", instr_count, 4);
        check("illop_pc", pc, 4);
`endif

        // Random programs
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int a = 0; a < 16; a++) begin
                w = 8'($urandom);
                if ($urandom_range(0, 7) != 0) w[7:4] = 4'($urandom_range(0, 9));
                prog[a] = w;
            end
            load_prog();
            run_prog(40);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
